// File: rtl/adc_idelay_calibrator.sv
// adc_idelay_calibrator
// Per-channel input-delay calibration sequencer for the LTC2387 capture datapath.
// Every channel sweeps taps 0..MAX_TAP in lockstep with the ADC test pattern enabled.
// Each unmasked channel is then parked at the centre of its widest error-free tap
// window, or at its pre-calibration tap if that window is shorter than MIN_WINDOW.
// Manual tap writes are accepted while idle.
// Build option: define ADC_CAL_DCO_CHECK_EN to add the bad_dco_counter input; a tap
// then also needs a zero DCO error count to be considered good.
module adc_idelay_calibrator #(
    parameter int NUM_CH        = 16,
    parameter int DELAY_BITS    = 9,
    parameter int MAX_TAP       = 511,
    parameter int SETTLE_CYCLES = 64,
    parameter int DWELL_CYCLES  = 4096,
    parameter int MIN_WINDOW    = 8,
    parameter int DEFAULT_TAP   = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic [NUM_CH-1:0]            ch_mask,
    input  logic                         man_we,
    input  logic [NUM_CH*DELAY_BITS-1:0] man_delay,
    input  logic [NUM_CH*16-1:0]         bad_data_counter,
`ifdef ADC_CAL_DCO_CHECK_EN
    input  logic [NUM_CH*16-1:0]         bad_dco_counter,
`endif
    output logic [NUM_CH*DELAY_BITS-1:0] ch_delay,
    output logic [NUM_CH-1:0]            ch_load,
    output logic                         adc_testpat,
    output logic                         clear_counters,
    output logic                         busy,
    output logic                         done,
    output logic [NUM_CH-1:0]            ch_fail,
    output logic [NUM_CH*DELAY_BITS-1:0] ch_window
);

    // Window lengths need one extra bit: a fully good sweep is MAX_TAP+1 taps long.
    localparam int LEN_W   = DELAY_BITS + 1;
    localparam int CNT_MAX = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [DELAY_BITS-1:0] LAST_TAP    = DELAY_BITS'(MAX_TAP);
    localparam logic [DELAY_BITS-1:0] RESET_TAP   = DELAY_BITS'(DEFAULT_TAP);
    localparam logic [LEN_W-1:0]      WIN_SAT     = LEN_W'((1 << DELAY_BITS) - 1);
    localparam logic [LEN_W-1:0]      MIN_LEN     = LEN_W'(MIN_WINDOW);
    localparam logic [CNT_W-1:0]      SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]      DWELL_LAST  = CNT_W'(DWELL_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SET_TAP,
        S_SETTLE,
        S_CLEAR,
        S_DWELL,
        S_SAMPLE,
        S_NEXT,
        S_FINAL,
        S_APPLY
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [CNT_W-1:0]        cnt;
    logic [DELAY_BITS-1:0]   tap;
    logic [NUM_CH-1:0]       mask_r;
    logic [NUM_CH-1:0]       good;

    logic [DELAY_BITS-1:0]   restore    [NUM_CH];
    logic [DELAY_BITS-1:0]   cur_start  [NUM_CH];
    logic [LEN_W-1:0]        cur_len    [NUM_CH];
    logic [DELAY_BITS-1:0]   best_start [NUM_CH];
    logic [LEN_W-1:0]        best_len   [NUM_CH];
    logic [DELAY_BITS-1:0]   target     [NUM_CH];
    logic [DELAY_BITS-1:0]   win_clip   [NUM_CH];
    logic [NUM_CH-1:0]       too_short;

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Next-state decode and the state-derived control outputs.
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        next_state     = state;
        busy           = (state != S_IDLE);
        done           = 1'b0;
        adc_testpat    = 1'b0;
        clear_counters = 1'b0;
        case (state)
            S_IDLE:    if (start) next_state = S_SET_TAP;
            S_SET_TAP: begin
                adc_testpat = 1'b1;
                next_state  = S_SETTLE;
            end
            S_SETTLE:  begin
                adc_testpat = 1'b1;
                if (cnt == SETTLE_LAST) next_state = S_CLEAR;
            end
            S_CLEAR:   begin
                adc_testpat    = 1'b1;
                clear_counters = 1'b1;
                next_state     = S_DWELL;
            end
            S_DWELL:   begin
                adc_testpat = 1'b1;
                if (cnt == DWELL_LAST) next_state = S_SAMPLE;
            end
            S_SAMPLE:  begin
                adc_testpat = 1'b1;
                next_state  = S_NEXT;
            end
            S_NEXT:    begin
                adc_testpat = 1'b1;
                next_state  = (tap == LAST_TAP) ? S_FINAL : S_SET_TAP;
            end
            S_FINAL:   begin
                adc_testpat = 1'b1;
                next_state  = S_APPLY;
            end
            S_APPLY:   begin
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default:   next_state = S_IDLE;
        endcase
        // Abort overrides every active state and suppresses the completion pulse.
        if (state != S_IDLE && abort) begin
            next_state = S_IDLE;
            done       = 1'b0;
        end
    end

    // Cycle counter for SETTLE and DWELL; restarts on every state change.
    always_ff @(posedge clk) begin
        if (rst || state != next_state)                 cnt <= '0;
        else if (state == S_SETTLE || state == S_DWELL) cnt <= cnt + CNT_W'(1);
    end

    // Good-tap test on the error counters for the current tap.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
`ifdef ADC_CAL_DCO_CHECK_EN
            good[i] = (bad_data_counter[i*16 +: 16] == 16'd0) &&
                      (bad_dco_counter[i*16 +: 16] == 16'd0);
`else
            good[i] = (bad_data_counter[i*16 +: 16] == 16'd0);
`endif
        end
    end

    // Restore snapshot and per-channel run trackers.
    // NOTE: these arrays have no reset; start loads every entry before any of them is read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (state == S_IDLE && start) begin
                restore[i]    <= ch_delay[i*DELAY_BITS +: DELAY_BITS];
                cur_start[i]  <= '0;
                cur_len[i]    <= '0;
                best_start[i] <= '0;
                best_len[i]   <= '0;
            end else if (state == S_SAMPLE) begin
                if (good[i]) begin
                    if (cur_len[i] == '0) cur_start[i] <= tap;
                    cur_len[i] <= cur_len[i] + LEN_W'(1);
                end else begin
                    // Strict compare: on a tie the earlier window is kept.
                    if (cur_len[i] > best_len[i]) begin
                        best_len[i]   <= cur_len[i];
                        best_start[i] <= cur_start[i];
                    end
                    cur_len[i] <= '0;
                end
            end else if (state == S_FINAL) begin
                // A run still open at MAX_TAP ends here; it does not wrap to tap 0.
                if (cur_len[i] > best_len[i]) begin
                    best_len[i]   <= cur_len[i];
                    best_start[i] <= cur_start[i];
                end
                cur_len[i] <= '0;
            end
        end
    end

    // Per-channel result: window centre, clipped window length and short-window flag.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            target[i]    = best_start[i] + DELAY_BITS'(best_len[i] >> 1);
            win_clip[i]  = (best_len[i] > WIN_SAT) ? WIN_SAT[DELAY_BITS-1:0]
                                                   : best_len[i][DELAY_BITS-1:0];
            too_short[i] = (best_len[i] < MIN_LEN);
        end
    end

    // Tap outputs, load strobes, sweep position and the published results.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) ch_delay[i*DELAY_BITS +: DELAY_BITS] <= RESET_TAP;
            ch_load   <= '0;
            ch_fail   <= '0;
            ch_window <= '0;
            mask_r    <= '0;
            tap       <= '0;
        end else begin
            ch_load <= '0;
            if (state != S_IDLE && abort) begin
                // Put unmasked channels back where they were before the run.
                for (int i = 0; i < NUM_CH; i++)
                    if (!mask_r[i]) ch_delay[i*DELAY_BITS +: DELAY_BITS] <= restore[i];
                ch_load <= ~mask_r;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            mask_r <= ch_mask;
                            tap    <= '0;
                        end else if (man_we) begin
                            ch_delay <= man_delay;
                            ch_load  <= '1;
                        end
                    end
                    S_SET_TAP: begin
                        for (int i = 0; i < NUM_CH; i++)
                            if (!mask_r[i]) ch_delay[i*DELAY_BITS +: DELAY_BITS] <= tap;
                        ch_load <= ~mask_r;
                    end
                    S_NEXT: if (tap != LAST_TAP) tap <= tap + DELAY_BITS'(1);
                    S_APPLY: begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (mask_r[i]) begin
                                ch_fail[i]                                <= 1'b0;
                                ch_window[i*DELAY_BITS +: DELAY_BITS]     <= '0;
                            end else begin
                                ch_fail[i]                                <= too_short[i];
                                ch_window[i*DELAY_BITS +: DELAY_BITS]     <= win_clip[i];
                                ch_delay[i*DELAY_BITS +: DELAY_BITS]      <=
                                    too_short[i] ? restore[i] : target[i];
                            end
                        end
                        ch_load <= ~mask_r;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
